// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared pipeline defines for the memory-access stage.
// Holds bus widths, write/stall encodings, the load/store opcodes,
// the MEM-stage FSM state encodings and small opcode classification helpers.
package mem_access_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int AluOpBus   = 8;

   localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  Stop         = 1'b1;
   localparam logic                  NoStop       = 1'b0;

   localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_e;

   function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
   endfunction

   function automatic logic is_mem_op(input logic [AluOpBus-1:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP) || is_store_op(op);
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: req/ack data bus between the MEM stage and the data memory.
// The stage is the master; the memory (or its bus bridge) is the slave.
interface mem_access_if;
   import mem_access_pkg::*;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [RegBus-1:0] mem_addr_o;
   logic [3:0]        mem_sel_o;
   logic [RegBus-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [RegBus-1:0] mem_data_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
      input  mem_ack_i, mem_data_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
      output mem_ack_i, mem_data_i
   );

endinterface

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational big-endian byte-lane steering.
// Produces byte enables and replicated store data, and extracts/extends
// the addressed lane of the read word for loads. Lane 0 is bits [31:24].
module mem_lane_fmt
   import mem_access_pkg::*;
(
   input  logic [AluOpBus-1:0] aluop,
   input  logic [1:0]          addr_lo,
   input  logic [RegBus-1:0]   reg2,
   input  logic [RegBus-1:0]   rdata,
   output logic [3:0]          sel,
   output logic [RegBus-1:0]   wdata,
   output logic [RegBus-1:0]   rdata_fmt
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Pick the addressed byte and half-word out of the read word
   always_comb begin
      rbyte = rdata[7:0];
      unique case (addr_lo)
         2'b00:   rbyte = rdata[31:24];
         2'b01:   rbyte = rdata[23:16];
         2'b10:   rbyte = rdata[15:8];
         default: rbyte = rdata[7:0];
      endcase
      rhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   // Byte enables, store replication and load extension per opcode
   always_comb begin
      sel       = 4'b0000;
      wdata     = ZeroWord;
      rdata_fmt = ZeroWord;
      case (aluop)
         EXE_LB_OP: begin
            sel       = 4'b1000 >> addr_lo;
            rdata_fmt = {{24{rbyte[7]}}, rbyte};
         end
         EXE_LBU_OP: begin
            sel       = 4'b1000 >> addr_lo;
            rdata_fmt = {24'h000000, rbyte};
         end
         EXE_LH_OP: begin
            sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
            rdata_fmt = {{16{rhalf[15]}}, rhalf};
         end
         EXE_LHU_OP: begin
            sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
            rdata_fmt = {16'h0000, rhalf};
         end
         EXE_LW_OP: begin
            sel       = 4'b1111;
            rdata_fmt = rdata;
         end
         EXE_SB_OP: begin
            sel   = 4'b1000 >> addr_lo;
            wdata = {4{reg2[7:0]}};
         end
         EXE_SH_OP: begin
            sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
            wdata = {2{reg2[15:0]}};
         end
         EXE_SW_OP: begin
            sel   = 4'b1111;
            wdata = reg2;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage between EX/MEM and MEM/WB.
// Non-memory ops pass straight through; loads/stores run one req/ack bus
// transaction while stallreq_o holds the pipeline (IDLE -> BUSY -> DONE).
// Optional macro MEM_ACCESS_TIMEOUT_EN adds an ack timeout of ACK_WAIT_MAX
// BUSY cycles that aborts the access and pulses mem_err_o.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ACK_WAIT_MAX = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall,
   input  logic [RegAddrBus-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [RegBus-1:0]     wdata_i,
   input  logic [RegBus-1:0]     hi_i,
   input  logic [RegBus-1:0]     lo_i,
   input  logic                  whilo_i,
   input  logic [AluOpBus-1:0]   aluop_i,
   input  logic [RegBus-1:0]     mem_addr_i,
   input  logic [RegBus-1:0]     reg2_i,
   output logic [RegAddrBus-1:0] wd_o,
   output logic                  wreg_o,
   output logic [RegBus-1:0]     wdata_o,
   output logic [RegBus-1:0]     hi_o,
   output logic [RegBus-1:0]     lo_o,
   output logic                  whilo_o,
   mem_access_if.master          bus,
   output logic                  stallreq_o,
   output logic                  mem_err_o
);

   mem_state_e        state, state_next;
   logic [RegBus-1:0] load_data;
   logic [3:0]        fmt_sel;
   logic [RegBus-1:0] fmt_wdata;
   logic [RegBus-1:0] fmt_rdata;
   logic              mem_op;
   logic              store_op;
   logic              timeout_hit;
   logic              err_flag;
   logic              unused_stall;

   assign mem_op       = is_mem_op(aluop_i);
   assign store_op     = is_store_op(aluop_i);
   assign unused_stall = ^{stall[5], stall[3:0]};

   mem_lane_fmt u_lane_fmt (
      .aluop     (aluop_i),
      .addr_lo   (mem_addr_i[1:0]),
      .reg2      (reg2_i),
      .rdata     (bus.mem_data_i),
      .sel       (fmt_sel),
      .wdata     (fmt_wdata),
      .rdata_fmt (fmt_rdata)
   );

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [31:0] wait_cnt;

   assign timeout_hit = (state == MEM_BUSY) && !bus.mem_ack_i &&
                        (wait_cnt == 32'(ACK_WAIT_MAX - 1));

   // Count BUSY cycles; a missing ack aborts the access and leaves a sticky flag for DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         mem_err_o <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         mem_err_o <= timeout_hit;
         if (state == MEM_BUSY) wait_cnt <= wait_cnt + 32'd1;
         else                   wait_cnt <= '0;
         if (timeout_hit)                 err_flag <= 1'b1;
         else if (state_next == MEM_IDLE) err_flag <= 1'b0;
      end
   end
`else
   localparam int unused_ack_wait_max = ACK_WAIT_MAX;

   assign timeout_hit = 1'b0;
   assign err_flag    = 1'b0;
   assign mem_err_o   = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= MEM_IDLE;
      else      state <= state_next;
   end

   // Next state: DONE waits for the pipeline to release the MEM stage
   always_comb begin
      state_next = state;
      unique case (state)
         MEM_IDLE: if (mem_op) state_next = MEM_BUSY;
         MEM_BUSY: if (bus.mem_ack_i || timeout_hit) state_next = MEM_DONE;
         MEM_DONE: if (stall[4] == NoStop) state_next = MEM_IDLE;
         default:  state_next = MEM_IDLE;
      endcase
   end

   // Bus request launch in IDLE, completion and load-data capture in BUSY
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_req_o  <= 1'b0;
         bus.mem_we_o   <= 1'b0;
         bus.mem_addr_o <= ZeroWord;
         bus.mem_sel_o  <= 4'b0000;
         bus.mem_data_o <= ZeroWord;
         load_data      <= ZeroWord;
      end else begin
         if (state == MEM_IDLE && mem_op) begin
            bus.mem_req_o  <= 1'b1;
            bus.mem_we_o   <= store_op;
            bus.mem_addr_o <= {mem_addr_i[RegBus-1:2], 2'b00};
            bus.mem_sel_o  <= fmt_sel;
            bus.mem_data_o <= fmt_wdata;
         end else if (state == MEM_BUSY && (bus.mem_ack_i || timeout_hit)) begin
            bus.mem_req_o <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            if (bus.mem_ack_i) load_data <= fmt_rdata;
         end
      end
   end

   // Result outputs and stall request; memory ops suppress the write until DONE
   always_comb begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      hi_o       = hi_i;
      lo_o       = lo_i;
      whilo_o    = whilo_i;
      stallreq_o = 1'b0;
      if (!rst) begin
         wd_o    = NOPRegAddr;
         wreg_o  = WriteDisable;
         wdata_o = ZeroWord;
         hi_o    = ZeroWord;
         lo_o    = ZeroWord;
         whilo_o = WriteDisable;
      end else begin
         unique case (state)
            MEM_IDLE: begin
               if (mem_op) begin
                  stallreq_o = 1'b1;
                  wreg_o     = WriteDisable;
               end
            end
            MEM_BUSY: begin
               stallreq_o = 1'b1;
               wreg_o     = WriteDisable;
            end
            MEM_DONE: begin
               if (!store_op) wdata_o = load_data;
               if (err_flag)  wreg_o  = WriteDisable;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for the MEM stage.
// Plays the memory slave directly, drives directed and random load/store
// and pass-through traffic, and compares against an arithmetic byte-lane model.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [4:0]  wd_i, wd_o;
   logic        wreg_i, wreg_o, whilo_i, whilo_o;
   logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i;
   logic [31:0] wdata_o, hi_o, lo_o;
   logic [7:0]  aluop_i;
   logic        stallreq_o, mem_err_o;
   int          checks = 0;
   int          failures = 0;

   mem_access_if bus ();

   mem_access #(.ACK_WAIT_MAX(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .wd_i       (wd_i),
      .wreg_i     (wreg_i),
      .wdata_i    (wdata_i),
      .hi_i       (hi_i),
      .lo_i       (lo_i),
      .whilo_i    (whilo_i),
      .aluop_i    (aluop_i),
      .mem_addr_i (mem_addr_i),
      .reg2_i     (reg2_i),
      .wd_o       (wd_o),
      .wreg_o     (wreg_o),
      .wdata_o    (wdata_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .whilo_o    (whilo_o),
      .bus        (bus),
      .stallreq_o (stallreq_o),
      .mem_err_o  (mem_err_o)
   );

   // Free-running stage clock
   always #5 clk = ~clk;

   // Safety net so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic isLoad(input logic [7:0] op);
      return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
             op == EXE_LHU_OP || op == EXE_LW_OP;
   endfunction

   function automatic logic isMem(input logic [7:0] op);
      return isLoad(op) || op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
   endfunction

   function automatic int opSize(input logic [7:0] op);
      if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
      if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
      return 1;
   endfunction

   // Byte offset of the access from the most significant lane
   function automatic int laneOffset(input logic [7:0] op, input logic [31:0] addr);
      int size;
      size = opSize(op);
      if (size == 4) return 0;
      if (size == 2) return int'(addr & 32'd2);
      return int'(addr & 32'd3);
   endfunction

   function automatic logic [3:0] refSel(input logic [7:0] op, input logic [31:0] addr);
      logic [3:0] s;
      int off, size;
      s = 4'b0000;
      off = laneOffset(op, addr);
      size = opSize(op);
      for (int i = 0; i < size; i++) s[3 - (off + i)] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] refStore(input logic [7:0] op, input logic [31:0] r2);
      logic [31:0] v;
      int size;
      v = 32'h0;
      size = opSize(op);
      for (int i = 0; i < 4; i++)
         v = (v << 8) | ((r2 >> (8 * ((size - 1) - (i % size)))) & 32'hFF);
      return v;
   endfunction

   function automatic logic [31:0] refLoad(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
      logic [31:0] raw;
      int size, off;
      size = opSize(op);
      off = laneOffset(op, addr);
      raw = rdata >> (8 * (4 - off - size));
      if (size < 4) begin
         raw = raw & ((32'd1 << (8 * size)) - 32'd1);
         if ((op == EXE_LB_OP || op == EXE_LH_OP) && raw >= (32'd1 << (8 * size - 1)))
            raw = raw - (32'd1 << (8 * size));
      end
      return raw;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One non-memory instruction, optionally with a stray ack on the bus
   task automatic nonMemStep(input logic ackNoise);
      logic [7:0] op;
      do op = 8'($urandom); while (isMem(op));
      aluop_i = op;
      wd_i = 5'($urandom);
      wreg_i = 1'($urandom);
      wdata_i = $urandom;
      hi_i = $urandom;
      lo_i = $urandom;
      whilo_i = 1'($urandom);
      stall = 6'b000000;
      bus.mem_ack_i = ackNoise;
      bus.mem_data_i = $urandom;
      #1;
      checkOutput("pass_wd", wd_o, wd_i);
      checkOutput("pass_wreg", wreg_o, wreg_i);
      checkOutput("pass_wdata", wdata_o, wdata_i);
      checkOutput("pass_hi", hi_o, hi_i);
      checkOutput("pass_lo", lo_o, lo_i);
      checkOutput("pass_whilo", whilo_o, whilo_i);
      checkOutput("pass_stallreq", stallreq_o, 0);
      checkOutput("pass_req", bus.mem_req_o, 0);
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      checkOutput("pass_req_after", bus.mem_req_o, 0);
   endtask

   // One full load/store: ack in BUSY cycle ackDelay, DONE held for hold cycles
   task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] r2, input logic [31:0] rdata,
                                input int ackDelay, input int hold);
      logic [4:0]  wd;
      logic [31:0] wdat, expResult;
      int stalls;
      wd = 5'($urandom);
      wdat = $urandom;
      aluop_i = op;
      mem_addr_i = addr;
      reg2_i = r2;
      wd_i = wd;
      wreg_i = isLoad(op);
      wdata_i = wdat;
      whilo_i = 1'b0;
      stall = 6'b000000;
      bus.mem_ack_i = 1'b0;
      #1;
      stalls = int'(stallreq_o);
      checkOutput("idle_stallreq", stallreq_o, 1);
      checkOutput("idle_wreg", wreg_o, 0);
      checkOutput("idle_req", bus.mem_req_o, 0);
      @(posedge clk); #1;
      checkOutput("busy_we", bus.mem_we_o, !isLoad(op));
      checkOutput("busy_addr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
      checkOutput("busy_sel", bus.mem_sel_o, refSel(op, addr));
      if (!isLoad(op)) checkOutput("busy_data", bus.mem_data_o, refStore(op, r2));
      for (int c = 1; c <= ackDelay; c++) begin
         checkOutput("busy_req", bus.mem_req_o, 1);
         checkOutput("busy_stallreq", stallreq_o, 1);
         checkOutput("busy_wreg", wreg_o, 0);
         stalls += int'(stallreq_o);
         if (c == ackDelay) begin
            bus.mem_ack_i = 1'b1;
            bus.mem_data_i = rdata;
         end else begin
            bus.mem_data_i = $urandom;
         end
         @(posedge clk); #1;
         bus.mem_ack_i = 1'b0;
         bus.mem_data_i = $urandom;
      end
      expResult = isLoad(op) ? refLoad(op, addr, rdata) : wdat;
      for (int h = 0; h <= hold; h++) begin
         stall = (h < hold) ? 6'b011111 : 6'b000000;
         #1;
         checkOutput("done_stallreq", stallreq_o, 0);
         checkOutput("done_req", bus.mem_req_o, 0);
         checkOutput("done_wdata", wdata_o, expResult);
         checkOutput("done_wreg", wreg_o, isLoad(op));
         checkOutput("done_wd", wd_o, wd);
         checkOutput("done_err", mem_err_o, 0);
         @(posedge clk); #1;
      end
      stall = 6'b000000;
      checkOutput("stall_cycles", stalls, ackDelay + 1);
   endtask

   // Directed scenarios followed by random traffic
   initial begin
      logic [7:0] memOps [8];
      memOps = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                 EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
      rst = 1'b0;
      stall = 6'b000000;
      aluop_i = 8'h21;
      wd_i = 5'd7;
      wreg_i = 1'b1;
      wdata_i = 32'hDEAD_BEEF;
      hi_i = 32'h1111_1111;
      lo_i = 32'h2222_2222;
      whilo_i = 1'b1;
      mem_addr_i = 32'h0;
      reg2_i = 32'h0;
      bus.mem_ack_i = 1'b0;
      bus.mem_data_i = 32'h0;
      #2;
      checkOutput("rst_wd", wd_o, 0);
      checkOutput("rst_wreg", wreg_o, 0);
      checkOutput("rst_wdata", wdata_o, 0);
      checkOutput("rst_hi", hi_o, 0);
      checkOutput("rst_whilo", whilo_o, 0);
      checkOutput("rst_stallreq", stallreq_o, 0);
      checkOutput("rst_req", bus.mem_req_o, 0);
      checkOutput("rst_sel", bus.mem_sel_o, 0);
      checkOutput("rst_addr", bus.mem_addr_o, 0);
      checkOutput("rst_err", mem_err_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      $display("[TB] non-memory pass-through");
      aluop_i = 8'h21;
      wd_i = 5'd3;
      wreg_i = 1'b1;
      wdata_i = 32'h0000_1234;
      #1;
      checkOutput("nm_wd", wd_o, 3);
      checkOutput("nm_wreg", wreg_o, 1);
      checkOutput("nm_wdata", wdata_o, 32'h0000_1234);
      checkOutput("nm_stallreq", stallreq_o, 0);
      @(posedge clk); #1;
      checkOutput("nm_req", bus.mem_req_o, 0);

      $display("[TB] directed loads and stores");
      applyStimulus(EXE_LB_OP, 32'h0000_0101, 32'h0, 32'h11F2_3344, 2, 0);
      applyStimulus(EXE_SH_OP, 32'h0000_0202, 32'hABCD_1234, 32'h0, 1, 0);
      applyStimulus(EXE_LW_OP, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1, 2);
      applyStimulus(EXE_LHU_OP, 32'h0000_0012, 32'h0, 32'h0000_BEEF, 3, 0);
      nonMemStep(1'b1);

      $display("[TB] reset during BUSY");
      aluop_i = EXE_LW_OP;
      mem_addr_i = 32'h0000_0300;
      wd_i = 5'd5;
      wreg_i = 1'b1;
      wdata_i = 32'h55;
      #1;
      @(posedge clk); #1;
      checkOutput("rb_req_before", bus.mem_req_o, 1);
      rst = 1'b0;
      #1;
      checkOutput("rb_req", bus.mem_req_o, 0);
      checkOutput("rb_we", bus.mem_we_o, 0);
      checkOutput("rb_addr", bus.mem_addr_o, 0);
      checkOutput("rb_sel", bus.mem_sel_o, 0);
      checkOutput("rb_data", bus.mem_data_o, 0);
      checkOutput("rb_stallreq", stallreq_o, 0);
      checkOutput("rb_wdata", wdata_o, 0);
      checkOutput("rb_wreg", wreg_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      aluop_i = 8'h00;
      wreg_i = 1'b0;
      wdata_i = 32'h77;
      bus.mem_ack_i = 1'b1;
      bus.mem_data_i = 32'hFFFF_FFFF;
      #1;
      checkOutput("rb_ack_stallreq", stallreq_o, 0);
      checkOutput("rb_ack_wdata", wdata_o, 32'h77);
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      checkOutput("rb_post_req", bus.mem_req_o, 0);
      checkOutput("rb_post_stallreq", stallreq_o, 0);
      checkOutput("rb_post_wdata", wdata_o, 32'h77);

      $display("[TB] random traffic");
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) nonMemStep(1'($urandom));
         else applyStimulus(memOps[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                            int'($urandom_range(1, 3)), int'($urandom_range(0, 1)));
      end

`ifdef MEM_ACCESS_TIMEOUT_EN
      $display("[TB] ack timeout");
      aluop_i = EXE_LW_OP;
      mem_addr_i = 32'h0000_0400;
      wd_i = 5'd9;
      wreg_i = 1'b1;
      stall = 6'b000000;
      bus.mem_ack_i = 1'b0;
      #1;
      @(posedge clk); #1;
      for (int c = 1; c <= 4; c++) begin
         checkOutput("to_busy_req", bus.mem_req_o, 1);
         checkOutput("to_busy_err", mem_err_o, 0);
         @(posedge clk); #1;
      end
      checkOutput("to_done_req", bus.mem_req_o, 0);
      checkOutput("to_done_err", mem_err_o, 1);
      checkOutput("to_done_wreg", wreg_o, 0);
      checkOutput("to_done_stallreq", stallreq_o, 0);
      @(posedge clk); #1;
      aluop_i = 8'h21;
      #1;
      checkOutput("to_after_err", mem_err_o, 0);
      checkOutput("to_after_stallreq", stallreq_o, 0);
      checkOutput("to_after_wreg", wreg_o, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
